// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one burst memory port between fetch (0) and data (1) caches.
// Data wins collisions; a starvation counter forces a fetch grant after MAX_CONSEC data wins.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LEN_W      = 8,
    parameter int MAX_CONSEC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          m_req_valid,
    output logic [1:0]          m_req_ready,
    input  logic [2*ADDR_W-1:0] m_req_addr,
    input  logic [1:0]          m_req_write,
    input  logic [2*LEN_W-1:0]  m_req_len,
    input  logic [1:0]          m_wvalid,
    input  logic [1:0]          m_wlast,
    input  logic [2*DATA_W-1:0] m_wdata,
    output logic [1:0]          m_wready,
    output logic [1:0]          m_rvalid,
    output logic [1:0]          m_rlast,
    output logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rready,
    output logic [1:0]          m_bvalid,
    input  logic [1:0]          m_bready,
    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_req_addr,
    output logic                s_req_write,
    output logic [LEN_W-1:0]    s_req_len,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic                s_wlast,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_rlast,
    input  logic                s_bvalid,
    output logic                s_bready,
    output logic                grant_id,
    output logic                busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADDR  = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] WRESP = 2'd3;
    localparam logic [3:0] MAXC  = 4'(MAX_CONSEC);
    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic       g, wr, win, in_a, in_r, in_w, in_b;
    always_comb begin
        win         = &m_req_valid ? (starve_cnt != MAXC) : m_req_valid[1];
        in_a        = state == ADDR;
        in_r        = state == DATA && !wr;
        in_w        = state == DATA && wr;
        in_b        = state == WRESP;
        s_req_valid = in_a;
        s_req_addr  = g ? m_req_addr[2*ADDR_W-1:ADDR_W] : m_req_addr[ADDR_W-1:0];
        s_req_len   = g ? m_req_len[2*LEN_W-1:LEN_W] : m_req_len[LEN_W-1:0];
        s_req_write = m_req_write[g];
        m_req_ready = 2'(in_a & s_req_ready) << g;
        s_wvalid    = in_w & m_wvalid[g];
        s_wlast     = in_w & m_wlast[g];
        s_wdata     = g ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
        m_wready    = 2'(in_w & s_wready) << g;
        s_rready    = in_r & m_rready[g];
        m_rvalid    = 2'(in_r & s_rvalid) << g;
        m_rlast     = 2'(in_r & s_rlast) << g;
        m_rdata     = s_rdata;
        m_bvalid    = 2'(in_b & s_bvalid) << g;
        s_bready    = in_b & m_bready[g];
        grant_id    = g;
        busy        = state != IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            g          <= 1'b0;
            wr         <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: if (|m_req_valid) begin
                    g          <= win;
                    // only a data win over a waiting fetch counts toward starvation
                    starve_cnt <= (win && m_req_valid[0]) ? (starve_cnt == MAXC ? MAXC : starve_cnt + 4'd1) : 4'd0;
                    state      <= ADDR;
                end
                ADDR: if (s_req_ready) begin
                    wr    <= m_req_write[g];
                    state <= DATA;
                end
                DATA: if (wr ? (s_wvalid & s_wready & s_wlast) : (s_rvalid & s_rready & s_rlast))
                    state <= wr ? WRESP : IDLE;
                default: if (s_bvalid & s_bready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters and memory model; scoreboard queues checked by a monitor.
module tb_mem_port_arbiter;
    localparam int MAXC = 4;
    typedef struct {
        bit          id;
        logic [63:0] addr;
        bit          write;
        logic [7:0]  len;
        logic [63:0] data;
        bit          last;
    } item_t;
    logic clk = 0;
    logic rst = 1;
    logic [1:0] m_req_valid, m_req_ready, m_req_write, m_wvalid, m_wlast, m_wready;
    logic [1:0] m_rvalid, m_rlast, m_rready, m_bvalid, m_bready;
    logic [127:0] m_req_addr, m_wdata;
    logic [15:0] m_req_len;
    logic [63:0] m_rdata, s_req_addr, s_wdata, s_rdata;
    logic [7:0] s_req_len;
    logic s_req_valid, s_req_ready, s_req_write, s_wvalid, s_wready, s_wlast;
    logic s_rvalid, s_rready, s_rlast, s_bvalid, s_bready, grant_id, busy;
    logic rv[2], rw[2], wv[2], wl[2], rr[2], br[2];
    logic [63:0] ra[2], wd[2];
    logic [7:0] rl[2];
    bit mbusy[2];
    bit slv_b;
    int w_stall;
    item_t cmdq[$], reqq[$], rdq[$], wrq[$];
    int tests, fails, rd_cnt[2], wr_cnt, b_cnt, b_at_g0;
    string glog;

    assign m_req_valid = {rv[1], rv[0]};
    assign m_req_write = {rw[1], rw[0]};
    assign m_req_addr  = {ra[1], ra[0]};
    assign m_req_len   = {rl[1], rl[0]};
    assign m_wvalid    = {wv[1], wv[0]};
    assign m_wlast     = {wl[1], wl[0]};
    assign m_wdata     = {wd[1], wd[0]};
    assign m_rready    = {rr[1], rr[0]};
    assign m_bready    = {br[1], br[0]};

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
        .m_req_write(m_req_write), .m_req_len(m_req_len),
        .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wdata(m_wdata), .m_wready(m_wready),
        .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata), .m_rready(m_rready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
        .s_req_write(s_req_write), .s_req_len(s_req_len),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_s(input string name, input string act, input string exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got grants '%s', want '%s'", name, act, exp);
        end
    endtask

    function automatic bit take(ref item_t q[$], input bit id, output item_t it);
        it = '{default: 0};
        foreach (q[j]) if (q[j].id == id) begin
            it = q[j];
            q.delete(j);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [63:0] rdata_of(input logic [63:0] a, input int k);
        return a + 64'(k) * 64'h0101_0101_0101_0101;
    endfunction

    task automatic push(input bit id, input logic [63:0] a, input bit w, input int len, input logic [63:0] d);
        item_t c;
        c = '{default: 0};
        c.id = id; c.addr = a; c.write = w; c.len = 8'(len); c.data = d;
        cmdq.push_back(c);
    endtask

    // Requester model: takes its own commands in order, registers expectations, runs the burst.
    task automatic master(input bit i);
        item_t c, e;
        int k;
        bit ok;
        rv[i] = 0; rw[i] = 0; wv[i] = 0; wl[i] = 0; rr[i] = 0; br[i] = 0;
        ra[i] = '0; wd[i] = '0; rl[i] = '0;
        forever begin
            @(negedge clk);
            rv[i] = 0; wv[i] = 0; wl[i] = 0; rr[i] = 0; br[i] = 0;
            if (rst || !take(cmdq, i, c)) begin
                mbusy[i] = 0;
                continue;
            end
            mbusy[i] = 1;
            reqq.push_back(c);
            for (int b = 0; b <= int'(c.len); b++) begin
                e = c;
                e.last = (b == int'(c.len));
                if (c.write) begin
                    e.data = c.data + 64'(b) * 64'd17;
                    wrq.push_back(e);
                end else begin
                    e.data = rdata_of(c.addr, b);
                    rdq.push_back(e);
                end
            end
            rv[i] = 1; ra[i] = c.addr; rw[i] = c.write; rl[i] = c.len;
            ok = 0;
            forever begin
                #4;
                if (rst) break;
                if (m_req_ready[i]) begin ok = 1; break; end
                @(negedge clk);
            end
            if (!ok) continue;
            k = 0;
            if (c.write) begin
                while (k <= int'(c.len) && !rst) begin
                    @(negedge clk);
                    rv[i] = 0;
                    wv[i] = $urandom_range(0, 3) != 0;
                    wd[i] = c.data + 64'(k) * 64'd17;
                    wl[i] = (k == int'(c.len));
                    #4;
                    if (wv[i] && m_wready[i]) k++;
                end
                ok = 0;
                while (!ok && !rst) begin
                    @(negedge clk);
                    wv[i] = 0; wl[i] = 0;
                    br[i] = $urandom_range(0, 1) != 0;
                    #4;
                    if (br[i] && m_bvalid[i]) ok = 1;
                end
            end else begin
                ok = 0;
                while (!ok && !rst) begin
                    @(negedge clk);
                    rv[i] = 0;
                    rr[i] = $urandom_range(0, 3) != 0;
                    #4;
                    if (rr[i] && m_rvalid[i] && m_rlast[i]) ok = 1;
                end
            end
        end
    endtask

    initial master(0);
    initial master(1);

    // Memory model: one burst at a time, random ready/valid, read data derived from address.
    initial begin : slave
        logic [63:0] a;
        int l, k, d, stall;
        bit w, done;
        s_req_ready = 0; s_wready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = '0; s_bvalid = 0; slv_b = 0;
        forever begin
            @(negedge clk);
            s_rvalid = 0; s_rlast = 0; s_wready = 0; s_bvalid = 0; slv_b = 0;
            s_req_ready = $urandom_range(0, 1) != 0;
            #4;
            if (rst || !(s_req_valid && s_req_ready)) continue;
            a = s_req_addr; l = int'(s_req_len); w = s_req_write; stall = w_stall;
            k = 0;
            if (!w) begin
                while (k <= l && !rst) begin
                    @(negedge clk);
                    s_req_ready = 0;
                    s_rvalid = $urandom_range(0, 3) != 0;
                    s_rdata = rdata_of(a, k);
                    s_rlast = (k == l);
                    #4;
                    if (s_rvalid && s_rready) k++;
                end
            end else begin
                done = 0;
                while (!done && !rst) begin
                    @(negedge clk);
                    s_req_ready = 0;
                    s_wready = stall > 0 ? 1'b0 : ($urandom_range(0, 3) != 0);
                    if (stall > 0) stall--;
                    #4;
                    if (s_wvalid && s_wready && s_wlast) done = 1;
                end
                d = $urandom_range(0, 2);
                done = 0;
                while (!done && !rst) begin
                    @(negedge clk);
                    s_wready = 0; slv_b = 1;
                    s_bvalid = d == 0;
                    if (d > 0) d--;
                    #4;
                    if (s_bvalid && s_bready) done = 1;
                end
            end
        end
    end

    // Monitor: routing invariants, arbitration reference, scoreboard pops.
    initial begin : monitor
        item_t e;
        bit ok, pend, pred;
        int starve;
        pend = 0; starve = 0; pred = 0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                pend = 0; starve = 0;
                continue;
            end
            for (int j = 0; j < 2; j++)
                if (!busy || j != int'(grant_id))
                    check($sformatf("idle_outs_req%0d", j),
                          {m_req_ready[j], m_wready[j], m_rvalid[j], m_rlast[j], m_bvalid[j]}, 0);
            if (!busy) check("idle_s_outs", {s_req_valid, s_wvalid, s_rready, s_bready}, 0);
            if (pend) begin
                check("grant_id", grant_id, pred);
                check("req_latency", s_req_valid, 1);
                glog = {glog, grant_id ? "1" : "0"};
                pend = 0;
            end else if (!busy && m_req_valid != 0) begin
                pred = m_req_valid == 2'b11 ? (starve < MAXC) : m_req_valid[1];
                starve = (pred && m_req_valid[0]) ? (starve < MAXC ? starve + 1 : MAXC) : 0;
                pend = 1;
            end
            if (s_req_valid && s_req_ready) begin
                ok = take(reqq, grant_id, e);
                check("req_expected", ok, 1);
                if (ok) check("req_addr", s_req_addr, e.addr);
                if (ok) check("req_len_write", {s_req_len, s_req_write}, {e.len, e.write});
                if (!grant_id) b_at_g0 = b_cnt;
            end
            for (int j = 0; j < 2; j++)
                if (m_rvalid[j] && m_rready[j]) begin
                    rd_cnt[j]++;
                    ok = take(rdq, j[0], e);
                    check($sformatf("rd_expected%0d", j), ok, 1);
                    if (ok) check($sformatf("rd_data%0d", j), m_rdata, e.data);
                    if (ok) check($sformatf("rd_last%0d", j), m_rlast[j], e.last);
                end
            if (s_wvalid && s_wready) begin
                wr_cnt++;
                ok = take(wrq, grant_id, e);
                check("wr_expected", ok, 1);
                if (ok) check("wr_data", s_wdata, e.data);
                if (ok) check("wr_last", s_wlast, e.last);
            end
            for (int j = 0; j < 2; j++) if (m_bvalid[j] && m_bready[j]) b_cnt++;
            if (slv_b && busy) check("bvalid_mirror", m_bvalid[grant_id], s_bvalid);
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            #4;
            if (cmdq.size() == 0 && reqq.size() == 0 && rdq.size() == 0 && wrq.size() == 0 &&
                !busy && !mbusy[0] && !mbusy[1] && m_req_valid == 0) break;
            if (++n == 5000) begin
                tests++; fails++;
                $display("FAIL %s_timeout: still busy after %0d cycles", name, n);
                break;
            end
        end
    endtask

    initial begin : watchdog
        #900000;
        tests++; fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : main
        int r0, r1, w0, b0, n;
        w_stall = 0;
        repeat (3) @(negedge clk);
        #4;
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_outs", {m_req_ready, m_wready, m_rvalid, m_bvalid, s_req_valid, s_wvalid, s_rready, s_bready}, 0);
        @(negedge clk);
        rst = 0;
        #4;

        glog = ""; r0 = rd_cnt[0]; r1 = rd_cnt[1];
        push(0, 64'h1000, 0, 3, 0);
        wait_done("lone");
        check("lone_beats0", rd_cnt[0] - r0, 4);
        check("lone_beats1", rd_cnt[1] - r1, 0);
        check_s("lone_grant", glog, "0");

        glog = "";
        push(1, 64'h2000, 0, 2, 0);
        push(0, 64'h2100, 0, 1, 0);
        wait_done("collision");
        check_s("collision", glog, "10");

        glog = "";
        push(0, 64'h2800, 0, 0, 0);
        for (int i = 0; i < 6; i++) push(1, 64'h2900 + 64'(i) * 64'h40, 0, 0, 0);
        wait_done("starve");
        check_s("starvation", glog, "1111011");

        glog = ""; w0 = wr_cnt; b0 = b_cnt; w_stall = 3;
        push(1, 64'h3000, 1, 1, 64'hAA);
        wait_done("write");
        w_stall = 0;
        check("write_beats", wr_cnt - w0, 2);
        check("write_resp", b_cnt - b0, 1);
        check_s("write_grant", glog, "1");

        glog = ""; b0 = b_cnt; n = 0;
        push(1, 64'h4000, 1, 3, 64'h10);
        do begin
            @(negedge clk);
            #4;
            n++;
        end while (!(busy && grant_id) && n < 100);
        check("lock_data_granted", {busy, grant_id}, 2'b11);
        push(0, 64'h4100, 0, 0, 0);
        wait_done("lock");
        check_s("lock_order", glog, "10");
        check("lock_fetch_after_bresp", b_at_g0, b0 + 1);

        r0 = rd_cnt[0]; n = 0;
        push(0, 64'h5000, 0, 7, 0);
        while (rd_cnt[0] < r0 + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("midrst_beats_before", rd_cnt[0] - r0, 2);
        #1 rst = 1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_grant", grant_id, 0);
        check("midrst_outs", {m_req_ready, m_rvalid, m_rlast, m_wready, m_bvalid, s_req_valid, s_rready, s_wvalid, s_bready}, 0);
        reqq.delete(); rdq.delete(); wrq.delete(); cmdq.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        #4;
        glog = ""; r0 = rd_cnt[0];
        push(0, 64'h6000, 0, 1, 0);
        wait_done("after_rst");
        check("after_rst_beats", rd_cnt[0] - r0, 2);
        check_s("after_rst_grant", glog, "0");

        for (int i = 0; i < 40; i++) begin
            push($urandom_range(0, 1) != 0, {$urandom, $urandom}, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 5), {$urandom, $urandom});
            repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        wait_done("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one burst memory port between the instruction-fetch cache (requester 0) and the data cache (requester 1). It sits between the two cache refill/writeback ports and the bulk-to-AXI adapter in front of main memory. Each grant covers one whole burst: address handshake, all data beats, and, for writes, the write acknowledgement. Data-side requests have priority, and a starvation counter forces fetch-side grants so fetch always makes progress.

## Interface
- ADDR_W, 64, request address width
- DATA_W, 64, beat data width
- LEN_W, 8, burst length field width (beats minus one)
- MAX_CONSEC, 4, max consecutive data grants while fetch is waiting (1..15)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m_req_valid  in  2  per-requester request valid; bit i = requester i
- m_req_ready  out  2  per-requester request accepted
- m_req_addr  in  2*ADDR_W  request addresses, requester i in slice i
- m_req_write  in  2  1 = write burst
- m_req_len  in  2*LEN_W  beats minus one
- m_wvalid / m_wlast  in  2 each  write beat valid / last
- m_wdata  in  2*DATA_W  write data
- m_wready  out  2  write beat accepted
- m_rvalid / m_rlast  out  2 each  read beat valid / last
- m_rdata  out  DATA_W  read data, shared by both requesters and qualified by m_rvalid[i]
- m_rready  in  2  read beat accept
- m_bvalid  out  2  write complete
- m_bready  in  2  write complete accept
- s_req_valid, s_req_ready, s_req_addr, s_req_write, s_req_len  out/in/out/out/out  1/1/ADDR_W/1/LEN_W  downstream request
- s_wvalid, s_wready, s_wdata, s_wlast  out/in/out/out  1/1/DATA_W/1  downstream write beats
- s_rvalid, s_rready, s_rdata, s_rlast  in/out/in/in  1/1/DATA_W/1  downstream read beats
- s_bvalid, s_bready  in/out  1/1  downstream write completion
- grant_id  out  1  requester currently owning the port
- busy  out  1  a transaction is in progress (state is not IDLE)

## Operation
- States: IDLE, ADDR, DATA, WRESP.
- **IDLE**
  - All m_* and s_* handshake outputs are 0.
  - If any m_req_valid is set, choose a winner and register grant_id. Go to ADDR.
- **Winner selection**
  - If only one requester is valid, it wins.
  - If both are valid, requester 1 wins unless starve_cnt == MAX_CONSEC, in which case requester 0 wins.
- **starve_cnt** (4-bit)
  - Increments when requester 1 is granted while m_req_valid[0] is set.
  - Clears when requester 0 is granted.
  - Clears when requester 1 is granted while m_req_valid[0] is clear.
  - Saturates at MAX_CONSEC.
- **ADDR**
  - s_req_* is driven from the granted requester's slice.
  - m_req_ready[g] = s_req_ready; the other bit is 0.
  - On the s_req_valid & s_req_ready handshake, latch the write flag and go to DATA.
- **DATA, read**
  - s_rready = m_rready[g]; m_rvalid[g] = s_rvalid; m_rlast[g] = s_rlast; m_rdata = s_rdata.
  - A beat that handshakes with s_rlast = 1 returns to IDLE.
- **DATA, write**
  - s_wvalid = m_wvalid[g]; s_wdata and s_wlast come from slice g; m_wready[g] = s_wready.
  - A beat that handshakes with wlast = 1 goes to WRESP.
- **WRESP**
  - m_bvalid[g] = s_bvalid; s_bready = m_bready[g].
  - Handshake returns to IDLE.
- The non-granted requester sees all of its m_* outputs at 0 at all times.
- Beat counting is not done here. Termination is by last only; m_req_len is forwarded unchanged.
- Requesters hold m_req_valid and address/len/write stable until m_req_ready. A dropped request before grant is simply not selected.

## Timing
- **Reset:** state IDLE, grant_id = 0, starve_cnt = 0, busy = 0, all valid/ready outputs 0. Asynchronous reset mid-burst abandons the transaction; downstream is reset by the same rst.
- **Arbitration latency:** request seen in IDLE at cycle N gives s_req_valid high at N+1. s_req_valid depends only on registered state.
- **Bubble:** returning to IDLE costs one cycle before the next grant. Back-to-back bursts are therefore spaced by ≥1 idle cycle on s_req_valid.
- **Lock:** grant_id is stable from ADDR entry until the IDLE return. A request arriving mid-burst waits.
- **Pass-through:** data paths are combinational (zero added latency on beats). Ready signals are combinational pass-through of the grantee's ready.
- **Simultaneous events:** a last-beat handshake and a new request in the same cycle still go through IDLE. Both requests first valid in the same IDLE cycle are resolved per the priority rule.

## Test plan
- **Lone fetch read:** m_req_valid = 01, addr 0x1000, len 3 -> grant_id = 0, s_req_valid at +1 cycle, 4 beats routed to m_rvalid[0], IDLE after s_rlast, m_rvalid[1] never set.
- **Collision:** both requests valid in one cycle, starve_cnt = 0 -> data (1) granted first. Fetch is granted after the data burst plus 1 idle cycle.
- **Starvation:** MAX_CONSEC = 4, data requests continuously, fetch held valid -> grant sequence 1,1,1,1,0,1..., starve_cnt back to 0 after the fetch grant.
- **Data write, len 1, wdata 0xAA, 0xBB:** two beats with wlast on the second -> WRESP, and m_bvalid[1] mirrors s_bvalid. Backpressure with s_wready low for 3 cycles loses no beat.
- **Reset mid-read** after beat 2 of 8 -> all outputs 0 immediately, state IDLE. A fresh request after release is granted normally.
- **Grant lock:** fetch request asserted during a data write burst -> m_req_ready[0] stays 0 until WRESP completes.
